sha256_msg_padder: RTL

//  Upstream feeder for the SHA-256 compression core. Fetches a message of any word length

---
 rtl/sha256_msg_padder.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Reads a message of msg_len 32-bit words starting at message_addr from a
// synchronous-read memory. It appends the SHA-256 padding and streams the
// result as 16-word blocks.
// Padding after the message: 0x80000000, zero words, then the 64-bit
// bit-length. The high length word is always zero and the low word is
// msg_len*32.
//
// Output handshake (valid/ready): a word transfers on a rising clk edge where
// out_valid and out_ready are both 1. While out_valid=1 and out_ready=0, the
// signals out_word, out_last and out_final hold their values. out_valid never
// drops without a transfer except on reset. out_ready may change freely.
module sha256_msg_padder #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [LEN_W-1:0]  msg_len,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic              out_last,
    output logic              out_final,
    output logic [2:0]        dbg_state
);

    // The word index reaches msg_len+17 at most, so one extra bit suffices.
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  idx_q, idx_d;

    logic              busy_d, done_d, out_valid_d, out_last_d, out_final_d;
    logic [31:0]       out_word_d;
    logic [ADDR_W-1:0] mem_addr_d;

    logic              fire;
    logic [CNT_W-1:0]  idx_next;
    logic [CNT_W-1:0]  len_ext;
    logic [CNT_W-1:0]  start_last;
    logic [31:0]       pad_next;

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign dbg_state = state;

    assign fire     = out_valid && out_ready;
    assign idx_next = idx_q + CNT_W'(1);
    assign len_ext  = CNT_W'(len_q);
    // Last index of the padded stream: 16*ceil((len+3)/16) - 1.
    assign start_last = ((CNT_W'(msg_len) + CNT_W'(18)) & ~CNT_W'(15)) - CNT_W'(1);

    // Select the padding word that follows the current word (used only past the message).
    always_comb begin
        pad_next = 32'h0;
        if (idx_next == len_ext)
            pad_next = 32'h8000_0000;
        else if (idx_next == last_q)
            pad_next = 32'(len_q) << 5;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = (msg_len == '0) ? S_OUT : S_RD0;
            S_RD0:  state_nxt = S_RD1;
            S_RD1:  state_nxt = S_RD2;
            S_RD2:  state_nxt = S_OUT;
            S_OUT: begin
                if (fire) begin
                    if (idx_q == last_q)
                        state_nxt = S_IDLE;
                    else if (idx_next < len_ext)
                        state_nxt = S_RD0;
                    else
                        state_nxt = S_OUT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values, registered below.
    always_comb begin
        base_d      = base_q;
        len_d       = len_q;
        last_d      = last_q;
        idx_d       = idx_q;
        busy_d      = busy;
        done_d      = 1'b0;
        out_valid_d = out_valid;
        out_word_d  = out_word;
        out_last_d  = out_last;
        out_final_d = out_final;
        mem_addr_d  = mem_addr;
        case (state)
            S_IDLE: begin
                if (start) begin
                    base_d = message_addr;
                    len_d  = msg_len;
                    last_d = start_last;
                    idx_d  = '0;
                    busy_d = 1'b1;
                    if (msg_len == '0) begin
                        out_word_d  = 32'h8000_0000;
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        out_final_d = 1'b0;
                    end
                end
            end
            S_RD0: mem_addr_d = base_q + ADDR_W'(idx_q);
            S_RD1: ;
            S_RD2: begin
                out_word_d  = mem_read_data;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q[3:0] == 4'hF);
                out_final_d = (idx_q == last_q);
            end
            S_OUT: begin
                if (fire) begin
                    if (idx_q == last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_final_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d = idx_next;
                        if (idx_next < len_ext) begin
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            out_final_d = 1'b0;
                        end else begin
                            out_word_d  = pad_next;
                            out_last_d  = (idx_next[3:0] == 4'hF);
                            out_final_d = (idx_next == last_q);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q    <= '0;
            len_q     <= '0;
            last_q    <= '0;
            idx_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_word  <= 32'h0;
            out_last  <= 1'b0;
            out_final <= 1'b0;
            mem_addr  <= '0;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= out_valid_d;
            out_word  <= out_word_d;
            out_last  <= out_last_d;
            out_final <= out_final_d;
            mem_addr  <= mem_addr_d;
        end
    end

endmodule
